// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encoding, load_op codes and bus layouts for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned EX_TO_MEM_WD = 142;
    localparam int unsigned MEM_TO_WB_WD = 136;
    localparam int unsigned MEM_TO_ID_WD = 104;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LB   = 3'd1;
    localparam logic [2:0] LOAD_LBU  = 3'd2;
    localparam logic [2:0] LOAD_LH   = 3'd3;
    localparam logic [2:0] LOAD_LHU  = 3'd4;
    localparam logic [2:0] LOAD_LW   = 3'd5;

    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi_i;
        logic        lo_we;
        logic [31:0] lo_i;
        logic [31:0] pc;
        logic        mem_ren;
        logic [2:0]  load_op;
        logic [1:0]  addr_lo;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi_i;
        logic        lo_we;
        logic [31:0] lo_i;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

    typedef struct packed {
        logic        hi_we;
        logic [31:0] hi_i;
        logic        lo_we;
        logic [31:0] lo_i;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_id_t;

    // Codes 0, 6 and 7 are not loads.
    function automatic logic is_load_op(input logic [2:0] op);
        return (op >= LOAD_LB) && (op <= LOAD_LW);
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Little-endian byte/halfword lane select with sign or zero extension for loads.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic        is_load_o,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
    end

    // Halfword lane ignores addr_lo[0]; misalignment is trapped upstream.
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        result_o = 32'h0;
        case (load_op_i)
            LOAD_LB:  result_o = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: result_o = {24'h0, byte_sel};
            LOAD_LH:  result_o = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: result_o = {16'h0, half_sel};
            LOAD_LW:  result_o = rdata_i;
            default:  result_o = 32'h0;
        endcase
    end

    assign is_load_o = is_load_op(load_op_i);

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: EX->MEM pipeline register, stall-safe read-data hold, load alignment,
// and the MEM->WB / MEM->ID buses.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned StallBus = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0] mem_to_id_bus
);

    ex_to_mem_t  ex_to_mem_q, ex_to_mem_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_vld_q, hold_vld_d;

    logic        mem_stop;
    logic        wb_stop;
    logic        unused_stall;

    assign mem_stop     = (stall[3] == STOP);
    assign wb_stop      = (stall[4] == STOP);
    assign unused_stall = ^stall;

    always_comb begin
        ex_to_mem_d = ex_to_mem_q;
        if (mem_stop && !wb_stop) begin
            // WB drains while MEM is frozen: feed it a bubble.
            ex_to_mem_d = '0;
        end else if (!mem_stop) begin
            ex_to_mem_d = ex_to_mem_t'(ex_to_mem_bus);
        end
    end

    // SRAM output is only valid for one cycle; latch it on the first frozen edge.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        if (mem_stop && !hold_vld_q) begin
            hold_data_d = data_sram_rdata;
            hold_vld_d  = 1'b1;
        end else if (!mem_stop) begin
            hold_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_to_mem_q <= '0;
            hold_data_q <= 32'h0;
            hold_vld_q  <= 1'b0;
        end else begin
            ex_to_mem_q <= ex_to_mem_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
        end
    end

    logic [31:0] eff_rdata;
    logic        align_is_load;
    logic [31:0] align_result;
    logic [31:0] rf_wdata;

    assign eff_rdata = hold_vld_q ? hold_data_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .load_op_i (ex_to_mem_q.load_op),
        .addr_lo_i (ex_to_mem_q.addr_lo),
        .rdata_i   (eff_rdata),
        .is_load_o (align_is_load),
        .result_o  (align_result)
    );

    assign rf_wdata = (ex_to_mem_q.mem_ren && align_is_load) ? align_result
                                                             : ex_to_mem_q.ex_result;

    mem_to_wb_t wb;
    mem_to_id_t id;

    always_comb begin
        wb.hi_we    = ex_to_mem_q.hi_we;
        wb.hi_i     = ex_to_mem_q.hi_i;
        wb.lo_we    = ex_to_mem_q.lo_we;
        wb.lo_i     = ex_to_mem_q.lo_i;
        wb.pc       = ex_to_mem_q.pc;
        wb.rf_we    = ex_to_mem_q.rf_we;
        wb.rf_waddr = ex_to_mem_q.rf_waddr;
        wb.rf_wdata = rf_wdata;

        id.hi_we    = ex_to_mem_q.hi_we;
        id.hi_i     = ex_to_mem_q.hi_i;
        id.lo_we    = ex_to_mem_q.lo_we;
        id.lo_i     = ex_to_mem_q.lo_i;
        id.rf_we    = ex_to_mem_q.rf_we;
        id.rf_waddr = ex_to_mem_q.rf_waddr;
        id.rf_wdata = rf_wdata;
    end

    assign mem_to_wb_bus = wb;
    assign mem_to_id_bus = id;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, passthrough, load alignment, stall hold, bubble, async reset.
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [141:0] ex_bus;
    logic [31:0]  rdata;
    logic [135:0] wb_bus;
    logic [103:0] id_bus;

    int n_assert = 0;
    int n_fail   = 0;

    mem_stage #(
        .StallBus (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (wb_bus),
        .mem_to_id_bus   (id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [141:0] mk_ex(input logic hw, input logic [31:0] hi,
                                           input logic lw, input logic [31:0] lo,
                                           input logic [31:0] pc, input logic ren,
                                           input logic [2:0] op, input logic [1:0] alo,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] res);
        return {hw, hi, lw, lo, pc, ren, op, alo, we, wa, res};
    endfunction

    function automatic logic [135:0] mk_wb(input logic hw, input logic [31:0] hi,
                                           input logic lw, input logic [31:0] lo,
                                           input logic [31:0] pc, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        return {hw, hi, lw, lo, pc, we, wa, wd};
    endfunction

    function automatic logic [103:0] mk_id(input logic hw, input logic [31:0] hi,
                                           input logic lw, input logic [31:0] lo,
                                           input logic we, input logic [4:0] wa,
                                           input logic [31:0] wd);
        return {hw, hi, lw, lo, we, wa, wd};
    endfunction

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  ld_op  [6];
    logic [1:0]  ld_alo [6];
    logic [31:0] ld_exp [6];
    logic [159:0] rnd;

    initial begin
        ld_op[0] = 3'd1; ld_alo[0] = 2'd3; ld_exp[0] = 32'hFFFF_FF80;
        ld_op[1] = 3'd2; ld_alo[1] = 2'd3; ld_exp[1] = 32'h0000_0080;
        ld_op[2] = 3'd1; ld_alo[2] = 2'd1; ld_exp[2] = 32'h0000_007F;
        ld_op[3] = 3'd3; ld_alo[3] = 2'd2; ld_exp[3] = 32'hFFFF_80FF;
        ld_op[4] = 3'd4; ld_alo[4] = 2'd0; ld_exp[4] = 32'h0000_7F01;
        ld_op[5] = 3'd5; ld_alo[5] = 2'd0; ld_exp[5] = 32'h80FF_7F01;

        // Reset with random inputs.
        rst   = 1'b0;
        rnd   = {$urandom, $urandom, $urandom, $urandom, $urandom};
        ex_bus = rnd[141:0];
        stall = 6'($urandom);
        rdata = $urandom;
        step();
        step();
        check("reset_wb", wb_bus, '0);
        check("reset_id", {32'h0, id_bus}, '0);

        // Release between edges; nothing may change before the next edge.
        stall = 6'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_reset_wb", wb_bus, '0);
        check("post_reset_id", {32'h0, id_bus}, '0);

        // ALU passthrough.
        ex_bus = mk_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0010, 1'b0, 3'd0, 2'd0,
                       1'b1, 5'd8, 32'h1234_5678);
        step();
        check("alu_wb", wb_bus, mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0010, 1'b1, 5'd8,
                                      32'h1234_5678));
        check("alu_id", {32'h0, id_bus}, {32'h0, mk_id(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8,
                                                        32'h1234_5678)});

        // hi/lo passthrough.
        ex_bus = mk_ex(1'b1, 32'hCAFE_0001, 1'b1, 32'h0BAD_0002, 32'hBFC0_0014, 1'b0, 3'd0,
                       2'd0, 1'b0, 5'd0, 32'h0000_0009);
        step();
        check("hilo_wb", wb_bus, mk_wb(1'b1, 32'hCAFE_0001, 1'b1, 32'h0BAD_0002, 32'hBFC0_0014,
                                       1'b0, 5'd0, 32'h0000_0009));

        // Byte/half/word loads; data arrives while the load is in MEM.
        for (int i = 0; i < 6; i++) begin
            ex_bus = mk_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0100, 1'b1, ld_op[i], ld_alo[i],
                           1'b1, 5'd3, 32'hAAAA_5555);
            step();
            rdata = 32'h80FF_7F01;
            #1;
            check($sformatf("load_%0d", i), {104'h0, wb_bus[31:0]}, {104'h0, ld_exp[i]});
        end

        // mem_ren=0 with LW code, and mem_ren=1 with non-load code 6: ex_result wins.
        ex_bus = mk_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 3'd5, 2'd0, 1'b1, 5'd3,
                       32'hAAAA_5555);
        step();
        check("noren_lw", {104'h0, wb_bus[31:0]}, {104'h0, 32'hAAAA_5555});
        ex_bus = mk_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 3'd6, 2'd0, 1'b1, 5'd3,
                       32'h5555_AAAA);
        step();
        check("op6_notload", {104'h0, wb_bus[31:0]}, {104'h0, 32'h5555_AAAA});

        // Stall hold: LW in MEM, freeze MEM and WB, SRAM output changes.
        ex_bus = mk_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0200, 1'b1, 3'd5, 2'd0, 1'b1,
                       5'd9, 32'h0);
        step();
        rdata = 32'hDEAD_BEEF;
        #1;
        check("stall_pre", {104'h0, wb_bus[31:0]}, {104'h0, 32'hDEAD_BEEF});
        ex_bus = mk_ex(1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0204, 1'b0, 3'd0, 2'd0, 1'b1,
                       5'd10, 32'h1111_2222);
        stall = 6'b011000;
        for (int c = 0; c < 3; c++) begin
            step();
            rdata = 32'h0;
            #1;
            check($sformatf("stall_hold_%0d", c), wb_bus, mk_wb(1'b0, 32'h0, 1'b0, 32'h0,
                  32'hBFC0_0200, 1'b1, 5'd9, 32'hDEAD_BEEF));
            check($sformatf("stall_vld_%0d", c), {135'h0, dut.hold_vld_q}, 136'h1);
        end
        stall = 6'b0;
        step();
        check("release_wb", wb_bus, mk_wb(1'b0, 32'h0, 1'b0, 32'h0, 32'hBFC0_0204, 1'b1,
                                          5'd10, 32'h1111_2222));
        check("release_vld", {135'h0, dut.hold_vld_q}, 136'h0);

        // Bubble: MEM stopped, WB running.
        ex_bus = mk_ex(1'b1, 32'h1234_0000, 1'b0, 32'h0, 32'hBFC0_0300, 1'b0, 3'd0, 2'd0,
                       1'b1, 5'd11, 32'h7777_7777);
        stall = 6'b001000;
        step();
        check("bubble_wb", wb_bus, '0);
        check("bubble_id", {32'h0, id_bus}, '0);

        // Async reset while stalled.
        stall = 6'b0;
        ex_bus = mk_ex(1'b1, 32'h5, 1'b1, 32'h6, 32'hBFC0_0400, 1'b1, 3'd5, 2'd0, 1'b1,
                       5'd12, 32'h0);
        step();
        rdata = 32'h0123_4567;
        stall = 6'b011000;
        step();
        check("pre_rst_vld", {135'h0, dut.hold_vld_q}, 136'h1);
        check("pre_rst_wb", wb_bus, mk_wb(1'b1, 32'h5, 1'b1, 32'h6, 32'hBFC0_0400, 1'b1,
                                          5'd12, 32'h0123_4567));
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_wb", wb_bus, '0);
        check("async_rst_id", {32'h0, id_bus}, '0);
        check("async_rst_vld", {135'h0, dut.hold_vld_q}, 136'h0);
        #1;
        rst = 1'b1;
        stall = 6'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage of the 5-stage MIPS core. Sits between EX and WB.
- Registers the EX→MEM bus under stall control. Captures the synchronous data-SRAM read response and aligns/extends load data.
- Drives the MEM→WB bus consumed by WB, and the MEM→ID forwarding bus.
- Load requests are issued by EX. Read data returns the cycle after EX issues, i.e. while the load occupies this stage.

Parameters:
- EX_TO_MEM_WD, 142, width of ex_to_mem_bus (`defines.vh` macro)
- MEM_TO_WB_WD, 136, width of mem_to_wb_bus (`defines.vh` macro)
- MEM_TO_ID_WD, 104, width of mem_to_id_bus (`defines.vh` macro)
- StallBus, 6, stall vector width; stall[3] is this stage, stall[4] is WB

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-low (stage cleared while rst==0)
- stall  in  StallBus  pipeline stall vector (Stop=1, NoStop=0)
- ex_to_mem_bus  in  142  {hi_we, hi_i[31:0], lo_we, lo_i[31:0], pc[31:0], mem_ren, load_op[2:0], addr_lo[1:0], rf_we, rf_waddr[4:0], ex_result[31:0]}
- data_sram_rdata  in  32  data SRAM read word (valid the cycle after EX request)
- mem_to_wb_bus  out  136  {hi_we, hi_i, lo_we, lo_i, pc, rf_we, rf_waddr, rf_wdata}
- mem_to_id_bus  out  104  {hi_we, hi_i, lo_we, lo_i, rf_we, rf_waddr, rf_wdata} for ID bypass

Behaviour:

Pipeline register ex_to_mem_r, in priority order:
- rst==0 (async) → all zero.
- Else, at posedge with stall[3]==Stop and stall[4]==NoStop → load zero (bubble).
- Else, with stall[3]==NoStop → load ex_to_mem_bus.
- Otherwise hold.

Read-data hold register (hold_data[31:0], hold_vld):
- Both cleared by reset.
- At posedge with stall[3]==Stop and hold_vld==0: hold_data ← data_sram_rdata, hold_vld ← 1.
- At posedge with stall[3]==NoStop: hold_vld ← 0.
- Effective rdata = hold_vld ? hold_data : data_sram_rdata.
- Purpose: keeps load data stable while MEM is frozen, even if the SRAM output changes.

Load extraction is combinational from ex_to_mem_r and effective rdata. It applies only when mem_ren==1.
- Byte lane = addr_lo, little-endian: 0→[7:0], 1→[15:8], 2→[23:16], 3→[31:24].
- Halfword lane = addr_lo[1]: 0→[15:0], 1→[31:16]. addr_lo[0] is ignored.
- load_op codes:
  - 1 LB: sign-extend byte
  - 2 LBU: zero-extend byte
  - 3 LH: sign-extend half
  - 4 LHU: zero-extend half
  - 5 LW: full word
  - 0, 6, 7: treated as not-a-load.
- rf_wdata = (mem_ren && load_op in 1..5) ? extracted value : ex_result.

Bus outputs:
- hi/lo fields, pc, rf_we and rf_waddr pass through from ex_to_mem_r unchanged.
- Alignment faults are handled in EX; this stage never raises exceptions.

Reset and latency:
- Reset values: mem_to_wb_bus = 0 and mem_to_id_bus = 0, since every field derives from the zeroed register.
- Latency: 1 cycle from ex_to_mem_bus to mem_to_wb_bus.

Boundary cases:
- Bubble insertion forces rf_we=0, hi_we=0, lo_we=0, so no spurious writes occur in WB.
- Stall released in the same cycle new data arrives: the register loads new data and hold_vld clears.
- Reset asserted mid-stall: the register and hold state clear immediately.

Decomposition:
- Additions to `defines.vh`: EX_TO_MEM_WD, MEM_TO_WB_WD, MEM_TO_ID_WD, the load_op codes (LOAD_NONE/LB/LBU/LH/LHU/LW), Stop/NoStop.
- One natural sub-module: load_align (load_op, addr_lo, rdata → 32-bit result), purely combinational.
- Register and hold logic stay in mem_stage.

Test Plan:
- Reset: hold rst=0 with random inputs → mem_to_wb_bus==0 and mem_to_id_bus==0. Release rst → both stay 0 until the first clock edge.
- Passthrough ALU op: mem_ren=0, rf_we=1, waddr=5'd8, ex_result=32'h1234_5678, pc=32'hBFC0_0010 → next cycle rf_wdata=32'h1234_5678, pc=32'hBFC0_0010, rf_we=1.
- Byte/half loads, rdata=32'h80FF_7F01:
  - LB addr_lo=3 → 32'hFFFF_FF80
  - LBU addr_lo=3 → 32'h0000_0080
  - LB addr_lo=1 → 32'h0000_007F
  - LH addr_lo=2 → 32'hFFFF_80FF
  - LHU addr_lo=0 → 32'h0000_7F01
  - LW → 32'h80FF_7F01
- Stall hold: an LW is in MEM with rdata=32'hDEAD_BEEF. Assert stall[4:3]=2'b11 for 3 cycles while rdata changes to 32'h0 → rf_wdata stays 32'hDEAD_BEEF throughout. Release → the next instruction is accepted and hold_vld=0.
- Bubble: stall[3]=1, stall[4]=0 with a valid rf_we=1, hi_we=1 instruction at the input → next cycle mem_to_wb_bus==0.
- Async reset mid-stall: stall held, pulse rst=0 between clock edges → outputs go to 0 without waiting for a clock edge, and hold_vld==0.
